// File: rtl/fb_update_scheduler_pkg.sv
// rtl/fb_update_scheduler_pkg.sv - shared framebuffer geometry, code width and scheduler state encoding
package fb_update_scheduler_pkg;

    localparam int PX_WIDTH  = 160;
    localparam int PX_HEIGHT = 120;
    localparam int FB_CODE_W = 3;
    localparam int FB_ADDR_W = $clog2(PX_WIDTH * PX_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_SWAP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fb_update_scheduler.sv
// rtl/fb_update_scheduler.sv - round-robin vblank-only write arbiter and front/back swap for the double-buffered framebuffer
module fb_update_scheduler
    import fb_update_scheduler_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int CODE_W    = FB_CODE_W,
    parameter int MAX_BURST = 64
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              vblank,
    input  logic              swap_req,
    input  logic              req0,
    input  logic              req1,
    input  logic              last0,
    input  logic              last1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [CODE_W-1:0] data0,
    input  logic [CODE_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [CODE_W-1:0] wr_data,
    output logic              front_sel,
    output logic              swap
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    sched_state_t      state_q, state_d;
    logic              rr_q, rr_d;
    logic              pending_q, pending_d;
    logic              front_q, front_d;
    logic              swap_q, swap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [CODE_W-1:0] wr_data_q, wr_data_d;

    logic              accept;
    logic              cur_req;
    logic              cur_last;
    logic [ADDR_W-1:0] cur_addr;
    logic [CODE_W-1:0] cur_data;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        cur_req  = (state_q == ST_GNT0) ? req0  : req1;
        cur_last = (state_q == ST_GNT0) ? last0 : last1;
        cur_addr = (state_q == ST_GNT0) ? addr0 : addr1;
        cur_data = (state_q == ST_GNT0) ? data0 : data1;
        accept   = ((state_q == ST_GNT0) || (state_q == ST_GNT1)) && cur_req;
        cnt_inc  = cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        front_d   = front_q;
        swap_d    = 1'b0;
        pending_d = pending_q | swap_req;
        wr_en_d   = accept;
        // Back-buffer MSB comes from the front_sel seen at acceptance, not at the write cycle.
        wr_addr_d = accept ? {~front_q, cur_addr} : wr_addr_q;
        wr_data_d = accept ? cur_data : wr_data_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (vblank && pending_q) begin
                    state_d   = ST_SWAP;
                    front_d   = ~front_q;
                    swap_d    = 1'b1;
                    pending_d = swap_req;
                end else if (vblank && (req0 || req1)) begin
                    if (req0 && req1) begin
                        state_d = rr_q ? ST_GNT1 : ST_GNT0;
                    end else begin
                        state_d = req0 ? ST_GNT0 : ST_GNT1;
                    end
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                end
                if (accept && (cur_last || (cnt_inc == CNT_MAX))) begin
                    state_d = ST_IDLE;
                    rr_d    = (state_q == ST_GNT0);
                    cnt_d   = '0;
                end else if (!vblank || !cur_req) begin
                    // Suspension keeps rr_q so the interrupted writer resumes first.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            pending_q <= 1'b0;
            front_q   <= 1'b0;
            swap_q    <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            front_q   <= front_d;
            swap_q    <= swap_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign gnt0      = (state_q == ST_GNT0);
    assign gnt1      = (state_q == ST_GNT1);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign front_sel = front_q;
    assign swap      = swap_q;

endmodule

// File: tb/tb_fb_update_scheduler.sv
// tb/tb_fb_update_scheduler.sv - scoreboard bench for fb_update_scheduler
module tb_fb_update_scheduler;

    localparam int AW = 15;
    localparam int CW = 3;
    localparam int MB = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW:0]   addr;
        logic [CW-1:0] data;
    } exp_t;

    logic          dclk = 1'b0;
    logic          clr = 1'b1;
    logic          vblank = 1'b0;
    logic          swap_req = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          last0 = 1'b0, last1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [CW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, wr_en, front_sel, swap;
    logic [AW:0]   wr_addr;
    logic [CW-1:0] wr_data;

    beat_t wq0[$];
    beat_t wq1[$];
    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    acc_cnt0 = 0, acc_cnt1 = 0;
    logic  acc0_s = 1'b0, acc1_s = 1'b0;
    logic  prev_g0 = 1'b0, prev_g1 = 1'b0;

    fb_update_scheduler #(.ADDR_W(AW), .CODE_W(CW), .MAX_BURST(MB)) dut (
        .dclk(dclk), .clr(clr), .vblank(vblank), .swap_req(swap_req),
        .req0(req0), .req1(req1), .last0(last0), .last1(last1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .front_sel(front_sel), .swap(swap)
    );

    always #5 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_refresh();
        req0 = (wq0.size() != 0);
        req1 = (wq1.size() != 0);
        if (wq0.size() != 0) begin
            addr0 = wq0[0].addr; data0 = wq0[0].data; last0 = wq0[0].last;
        end
        if (wq1.size() != 0) begin
            addr1 = wq1[0].addr; data1 = wq1[0].data; last1 = wq1[0].last;
        end
    endtask

    task automatic push_exp(input logic msb, input int a, input int d);
        exp_t e;
        e.addr = {msb, AW'(a)};
        e.data = CW'(d);
        exp_q.push_back(e);
    endtask

    task automatic load_w(input int w, input int n, input int base, input int d,
                          input bit last_end, input logic msb, input bit push);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr = AW'(base + i);
            b.data = CW'(d);
            b.last = last_end && (i == n - 1);
            if (w == 0) wq0.push_back(b); else wq1.push_back(b);
            if (push) push_exp(msb, base + i, d);
        end
        drive_refresh();
    endtask

    task automatic cyc();
        @(posedge dclk);
        #2;
    endtask

    task automatic wait_acc(input int w, input int target, input string tag);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (((w == 0) ? acc_cnt0 : acc_cnt1) >= target) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (exp_q.size() == 0 && wq0.size() == 0 && wq1.size() == 0) begin
                repeat (3) cyc();
                return;
            end
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Writer model: a beat is consumed when gnt&req held across a rising edge.
    always @(negedge dclk) begin
        acc0_s = gnt0 & req0;
        acc1_s = gnt1 & req1;
    end

    always @(posedge dclk) begin
        #1;
        if (acc0_s && wq0.size() != 0) begin
            wq0.delete(0);
            acc_cnt0++;
        end
        if (acc1_s && wq1.size() != 0) begin
            wq1.delete(0);
            acc_cnt1++;
        end
        drive_refresh();
    end

    always @(negedge dclk) begin
        if (!clr) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", {16'd0, wr_addr}, 32'hffff_ffff);
                end else begin
                    chk("wr_addr", {16'd0, wr_addr}, {16'd0, exp_q[0].addr});
                    chk("wr_data", {29'd0, wr_data}, {29'd0, exp_q[0].data});
                    exp_q.delete(0);
                end
            end
            if (gnt0 && gnt1) chk("gnt_excl", 1, 0);
            if (gnt0 && !prev_g0) chk("gap_before_gnt0", {31'd0, prev_g1}, 0);
            if (gnt1 && !prev_g1) chk("gap_before_gnt1", {31'd0, prev_g0}, 0);
        end
        prev_g0 = gnt0;
        prev_g1 = gnt1;
    end

    initial begin
        int base;
        int early;
        repeat (3) @(posedge dclk);
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_front_sel", front_sel, 0);
        chk("rst_swap", swap, 0);
        clr = 1'b0;
        cyc();

        // Single burst on writer 0, then writer 1 served
        vblank = 1'b1;
        load_w(0, 4, 10, 5, 1'b1, 1'b1, 1'b1);
        load_w(1, 2, 100, 2, 1'b1, 1'b1, 1'b1);
        @(negedge dclk);
        chk("t1_gnt0_not_yet", gnt0, 0);
        @(negedge dclk);
        chk("t1_gnt0_latency", gnt0, 1);
        wait_drain("t1_drain");

        // Continuous requests, forced re-arbitration at MAX_BURST
        for (int i = 0; i < 16; i++) begin
            load_w(0, 1, 200 + i, i % 8, 1'b0, 1'b1, 1'b0);
            load_w(1, 1, 300 + i, (i + 3) % 8, 1'b0, 1'b1, 1'b0);
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < MB; i++) push_exp(1'b1, 200 + c * MB + i, (c * MB + i) % 8);
            for (int i = 0; i < MB; i++) push_exp(1'b1, 300 + c * MB + i, (c * MB + i + 3) % 8);
        end
        wait_drain("t2_drain");

        // vblank falls mid-burst; suspended writer 1 resumes first
        load_w(0, 1, 400, 1, 1'b1, 1'b1, 1'b1);
        wait_drain("t3_pre_drain");
        base = acc_cnt1;
        load_w(1, 8, 500, 6, 1'b1, 1'b1, 1'b1);
        wait_acc(1, base + 1, "t3_first_beat_timeout");
        vblank = 1'b0;
        @(negedge dclk);
        @(negedge dclk);
        chk("t3_gnt1_dropped", gnt1, 0);
        chk("t3_two_beats", acc_cnt1 - base, 2);
        load_w(0, 2, 600, 3, 1'b1, 1'b1, 1'b1);
        repeat (5) cyc();
        chk("t3_no_gnt0_active", gnt0, 0);
        vblank = 1'b1;
        @(negedge dclk);
        @(negedge dclk);
        chk("t3_gnt1_resumes", gnt1, 1);
        wait_drain("t3_drain");
        chk("t3_all_beats", acc_cnt1 - base, 8);

        // Swap requested during active video takes priority at vblank
        vblank = 1'b0;
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        load_w(0, 2, 700, 4, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc();
        chk("t4_front_hold", front_sel, 0);
        chk("t4_gnt0_hold", gnt0, 0);
        vblank = 1'b1;
        @(negedge dclk);
        @(negedge dclk);
        chk("t4_swap", swap, 1);
        chk("t4_front_sel", front_sel, 1);
        chk("t4_no_gnt_in_swap", gnt0, 0);
        @(negedge dclk);
        chk("t4_swap_one_cycle", swap, 0);
        @(negedge dclk);
        chk("t4_gnt0_after_swap", gnt0, 1);
        wait_drain("t4_drain");

        // Swap requested mid-burst waits for the burst to finish
        base = acc_cnt0;
        load_w(0, 6, 800, 7, 1'b1, 1'b0, 1'b1);
        wait_acc(0, base + 1, "t5_first_beat_timeout");
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        early = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge dclk);
            if (!gnt0) break;
            if (swap) early++;
        end
        chk("t5_no_swap_in_burst", early, 0);
        chk("t5_gnt0_fell", gnt0, 0);
        chk("t5_swap_not_yet", swap, 0);
        @(negedge dclk);
        chk("t5_swap", swap, 1);
        chk("t5_front_sel", front_sel, 0);
        wait_drain("t5_drain");

        // Asynchronous clear mid-burst
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        repeat (4) cyc();
        chk("t6_front_pre", front_sel, 1);
        base = acc_cnt0;
        load_w(0, 6, 900, 2, 1'b0, 1'b0, 1'b0);
        push_exp(1'b0, 900, 2);
        wait_acc(0, base + 2, "t6_beats_timeout");
        #1;
        clr = 1'b1;
        #1;
        chk("t6_gnt0", gnt0, 0);
        chk("t6_gnt1", gnt1, 0);
        chk("t6_wr_en", wr_en, 0);
        chk("t6_swap", swap, 0);
        chk("t6_front_sel", front_sel, 0);
        wq0.delete();
        drive_refresh();
        cyc();
        clr = 1'b0;
        repeat (10) cyc();
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_front_after", front_sel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
